// File: rtl/cp0_regfile.sv
`default_nettype none
// ============================================================================
// Module      : cp0_regfile
// Description : Coprocessor-0 register file for SimpleCPU. It serves the MFC0
//               and MTC0 ports, commits exception and ERET state, and runs
//               the Count/Compare timer (enabled by defining CP0_TIMER_EN).
// Revision    : 1.0 - initial release
// ============================================================================
module cp0_regfile #(
    parameter int                    DATA_WIDTH     = 32,
    parameter int                    CP0_ADDR_WIDTH = 5,
    parameter logic [DATA_WIDTH-1:0] PRID           = 32'h0001_8000
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      reg_rw,
    input  logic [CP0_ADDR_WIDTH-1:0] read_addr,
    output logic [DATA_WIDTH-1:0]     read_data,
    input  logic [CP0_ADDR_WIDTH-1:0] write_addr,
    input  logic [DATA_WIDTH-1:0]     write_data,
    input  logic [5:0]                int_i,
    input  logic                      exc_valid,
    input  logic [4:0]                exc_code,
    input  logic [DATA_WIDTH-1:0]     exc_pc,
    input  logic                      exc_in_delay_slot,
    input  logic                      eret,
    output logic                      timer_int,
    output logic                      int_pending,
    output logic [DATA_WIDTH-1:0]     epc_o,
    output logic [DATA_WIDTH-1:0]     status_o
);

    localparam logic [CP0_ADDR_WIDTH-1:0] ADDR_COUNT   = CP0_ADDR_WIDTH'(9);
    localparam logic [CP0_ADDR_WIDTH-1:0] ADDR_COMPARE = CP0_ADDR_WIDTH'(11);
    localparam logic [CP0_ADDR_WIDTH-1:0] ADDR_STATUS  = CP0_ADDR_WIDTH'(12);
    localparam logic [CP0_ADDR_WIDTH-1:0] ADDR_CAUSE   = CP0_ADDR_WIDTH'(13);
    localparam logic [CP0_ADDR_WIDTH-1:0] ADDR_EPC     = CP0_ADDR_WIDTH'(14);
    localparam logic [CP0_ADDR_WIDTH-1:0] ADDR_PRID    = CP0_ADDR_WIDTH'(15);

    logic [7:0]            status_im;
    logic                  status_exl;
    logic                  status_ie;
    logic                  cause_bd;
    logic [5:0]            cause_ip_hw;
    logic [1:0]            cause_ip_sw;
    logic [4:0]            cause_exc_code;
    logic [DATA_WIDTH-1:0] epc;

    logic wr_status;
    logic wr_cause;
    logic wr_epc;
    logic fwd;

    logic [DATA_WIDTH-1:0] status_val;
    logic [DATA_WIDTH-1:0] cause_val;
    logic [DATA_WIDTH-1:0] status_fwd;
    logic [DATA_WIDTH-1:0] cause_fwd;

    assign wr_status = reg_rw && (write_addr == ADDR_STATUS);
    assign wr_cause  = reg_rw && (write_addr == ADDR_CAUSE);
    assign wr_epc    = reg_rw && (write_addr == ADDR_EPC);
    assign fwd       = reg_rw && (write_addr == read_addr);

    assign status_val = {{(DATA_WIDTH-16){1'b0}}, status_im, 6'b0, status_exl, status_ie};
    assign cause_val  = {cause_bd, {(DATA_WIDTH-17){1'b0}}, cause_ip_hw, cause_ip_sw,
                         1'b0, cause_exc_code, 2'b0};
    assign status_fwd = {{(DATA_WIDTH-16){1'b0}}, write_data[15:8], 6'b0, write_data[1:0]};
    assign cause_fwd  = {cause_bd, {(DATA_WIDTH-17){1'b0}}, cause_ip_hw, write_data[9:8],
                         1'b0, cause_exc_code, 2'b0};

`ifdef CP0_TIMER_EN
    logic [DATA_WIDTH-1:0] count;
    logic [DATA_WIDTH-1:0] compare;
    logic                  wr_count;
    logic                  wr_compare;

    assign wr_count   = reg_rw && (write_addr == ADDR_COUNT);
    assign wr_compare = reg_rw && (write_addr == ADDR_COMPARE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count     <= '0;
            compare   <= '0;
            timer_int <= 1'b0;
        end else begin
            count <= wr_count ? write_data : count + DATA_WIDTH'(1);
            if (wr_compare) begin
                compare <= write_data;
            end
            // A Compare write acknowledges the interrupt and wins over a new match.
            if (wr_compare) begin
                timer_int <= 1'b0;
            end else if ((compare != '0) && (count == compare)) begin
                timer_int <= 1'b1;
            end
        end
    end
`else
    assign timer_int = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            status_im      <= '0;
            status_exl     <= 1'b0;
            status_ie      <= 1'b0;
            cause_bd       <= 1'b0;
            cause_ip_hw    <= '0;
            cause_ip_sw    <= '0;
            cause_exc_code <= '0;
            epc            <= '0;
        end else begin
            cause_ip_hw <= {int_i[5] | timer_int, int_i[4:0]};
            // An exception drops any concurrent ERET and MTC0 to Status/Cause/EPC.
            if (exc_valid) begin
                cause_exc_code <= exc_code;
                if (!status_exl) begin
                    epc        <= exc_in_delay_slot ? exc_pc - DATA_WIDTH'(4) : exc_pc;
                    cause_bd   <= exc_in_delay_slot;
                    status_exl <= 1'b1;
                end
            end else begin
                if (wr_status) begin
                    status_im  <= write_data[15:8];
                    status_exl <= write_data[1];
                    status_ie  <= write_data[0];
                end
                if (eret) begin
                    status_exl <= 1'b0;
                end
                if (wr_cause) begin
                    cause_ip_sw <= write_data[9:8];
                end
                if (wr_epc) begin
                    epc <= write_data;
                end
            end
        end
    end

    always_comb begin
        read_data = '0;
        case (read_addr)
`ifdef CP0_TIMER_EN
            ADDR_COUNT:   read_data = fwd ? write_data : count;
            ADDR_COMPARE: read_data = fwd ? write_data : compare;
`endif
            ADDR_STATUS:  read_data = fwd ? status_fwd : status_val;
            ADDR_CAUSE:   read_data = fwd ? cause_fwd : cause_val;
            ADDR_EPC:     read_data = fwd ? write_data : epc;
            ADDR_PRID:    read_data = PRID;
            default:      read_data = '0;
        endcase
    end

    assign int_pending = status_ie & ~status_exl &
                         (|({cause_ip_hw, cause_ip_sw} & status_im));
    assign epc_o       = epc;
    assign status_o    = status_val;

endmodule
`default_nettype wire

// File: tb/tb_cp0_regfile.sv
`default_nettype none
// ============================================================================
// Module      : tb_cp0_regfile
// Description : Directed self-checking bench for cp0_regfile.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cp0_regfile;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        reg_rw;
    logic [4:0]  read_addr;
    logic [31:0] read_data;
    logic [4:0]  write_addr;
    logic [31:0] write_data;
    logic [5:0]  int_i;
    logic        exc_valid;
    logic [4:0]  exc_code;
    logic [31:0] exc_pc;
    logic        exc_in_delay_slot;
    logic        eret;
    logic        timer_int;
    logic        int_pending;
    logic [31:0] epc_o;
    logic [31:0] status_o;

    int errors = 0;
    int checks = 0;

    cp0_regfile dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .reg_rw            (reg_rw),
        .read_addr         (read_addr),
        .read_data         (read_data),
        .write_addr        (write_addr),
        .write_data        (write_data),
        .int_i             (int_i),
        .exc_valid         (exc_valid),
        .exc_code          (exc_code),
        .exc_pc            (exc_pc),
        .exc_in_delay_slot (exc_in_delay_slot),
        .eret              (eret),
        .timer_int         (timer_int),
        .int_pending       (int_pending),
        .epc_o             (epc_o),
        .status_o          (status_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic rd(input logic [4:0] a, input string tag, input logic [31:0] exp);
        read_addr = a;
        #1;
        check(tag, read_data, exp);
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        reg_rw     = 1'b1;
        write_addr = a;
        write_data = d;
    endtask

    initial begin
        rst_n = 1'b0; reg_rw = 1'b0; read_addr = '0; write_addr = '0; write_data = '0;
        int_i = '0; exc_valid = 1'b0; exc_code = '0; exc_pc = '0;
        exc_in_delay_slot = 1'b0; eret = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;

        // Reset state
        rd(5'd9,  "rst_count",   32'h0);
        rd(5'd11, "rst_compare", 32'h0);
        rd(5'd12, "rst_status",  32'h0);
        rd(5'd13, "rst_cause",   32'h0);
        rd(5'd14, "rst_epc",     32'h0);
        rd(5'd15, "rst_prid",    32'h0001_8000);
        rd(5'd3,  "unmapped",    32'h0);
        check("rst_int_pending", {31'b0, int_pending}, 32'h0);
        check("rst_epc_o",       epc_o,    32'h0);
        check("rst_status_o",    status_o, 32'h0);

`ifdef CP0_TIMER_EN
        begin
            bit found = 1'b0;
            mtc0(5'd11, 32'd10);
            tick();
            mtc0(5'd9, 32'd5);
            tick();
            reg_rw = 1'b0;
            rd(5'd9, "count_after_write", 32'd5);
            for (int i = 0; i < 20; i++) begin
                read_addr = 5'd9;
                #1;
                if (read_data == 32'd10) begin
                    found = 1'b1;
                    break;
                end
                tick();
            end
            check("count_reaches_10", {31'b0, found}, 32'h1);
            check("timer_before_rise", {31'b0, timer_int}, 32'h0);
            tick();
            check("timer_rise", {31'b0, timer_int}, 32'h1);
            mtc0(5'd11, 32'd20);
            tick();
            reg_rw = 1'b0;
            check("timer_clear", {31'b0, timer_int}, 32'h0);
            mtc0(5'd11, 32'd0);
            tick();
            reg_rw = 1'b0;
        end
`else
        mtc0(5'd9, 32'd7);
        rd(5'd9, "count_nofwd", 32'h0);
        tick();
        reg_rw = 1'b0;
        rd(5'd9, "count_disabled", 32'h0);
        mtc0(5'd11, 32'd3);
        tick();
        reg_rw = 1'b0;
        rd(5'd11, "compare_disabled", 32'h0);
        repeat (5) tick();
        check("timer_tied0", {31'b0, timer_int}, 32'h0);
`endif

        // Status write with forwarding, then hardware interrupt
        mtc0(5'd12, 32'h0000_8001);
        rd(5'd12, "status_fwd", 32'h0000_8001);
        tick();
        reg_rw = 1'b0;
        check("status_o_8001", status_o, 32'h0000_8001);
        int_i = 6'b100000;
        #1;
        check("int_pending_lag", {31'b0, int_pending}, 32'h0);
        tick();
        check("int_pending_set", {31'b0, int_pending}, 32'h1);

        // Exception entry, not in delay slot
        exc_valid = 1'b1; exc_code = 5'd0; exc_pc = 32'h100; exc_in_delay_slot = 1'b0;
        tick();
        exc_valid = 1'b0;
        check("exc1_epc",    epc_o,    32'h0000_0100);
        check("exc1_status", status_o, 32'h0000_8003);
        check("exc1_intp",   {31'b0, int_pending}, 32'h0);
        rd(5'd13, "exc1_cause", 32'h0000_8000);

        eret = 1'b1;
        tick();
        eret = 1'b0;
        check("eret_status", status_o, 32'h0000_8001);
        check("eret_intp",   {31'b0, int_pending}, 32'h1);

        // Exception in delay slot
        exc_valid = 1'b1; exc_code = 5'd4; exc_pc = 32'h204; exc_in_delay_slot = 1'b1;
        tick();
        check("exc2_epc", epc_o, 32'h0000_0200);
        rd(5'd13, "exc2_cause", 32'h8000_8010);

        // Nested exception while EXL=1
        exc_code = 5'd5; exc_pc = 32'h300; exc_in_delay_slot = 1'b0;
        tick();
        exc_valid = 1'b0;
        check("exc3_epc_hold", epc_o, 32'h0000_0200);
        rd(5'd13, "exc3_cause", 32'h8000_8014);

        // EPC write forwarded in the same cycle
        mtc0(5'd14, 32'h400);
        rd(5'd14, "epc_fwd", 32'h0000_0400);
        tick();
        reg_rw = 1'b0;
        check("epc_written", epc_o, 32'h0000_0400);

        // Status write together with ERET: EXL cleared, other bits written
        mtc0(5'd12, 32'hFFFF_FFFF);
        eret  = 1'b1;
        int_i = 6'b000000;
        tick();
        reg_rw = 1'b0;
        eret   = 1'b0;
        check("status_eret", status_o, 32'h0000_FF01);
        rd(5'd13, "cause_ip_clear", 32'h8000_0014);
        check("intp_none", {31'b0, int_pending}, 32'h0);

        // Cause write: only software IP bits change
        mtc0(5'd13, 32'hFFFF_FFFF);
        rd(5'd13, "cause_fwd", 32'h8000_0314);
        tick();
        reg_rw = 1'b0;
        rd(5'd13, "cause_sw", 32'h8000_0314);
        check("intp_sw", {31'b0, int_pending}, 32'h1);

        // Exception beats a concurrent EPC write
        mtc0(5'd14, 32'h500);
        exc_valid = 1'b1; exc_code = 5'd3; exc_pc = 32'h600; exc_in_delay_slot = 1'b0;
        tick();
        reg_rw = 1'b0;
        exc_valid = 1'b0;
        check("exc_over_mtc0", epc_o, 32'h0000_0600);
        rd(5'd13, "exc4_cause", 32'h0000_030C);
        check("exc4_status", status_o, 32'h0000_FF03);

        // Reset wins over concurrent activity
        rst_n = 1'b0;
        mtc0(5'd14, 32'h700);
        exc_valid = 1'b1; exc_pc = 32'h800;
        tick();
        rst_n = 1'b1;
        reg_rw = 1'b0;
        exc_valid = 1'b0;
        check("rst2_epc",    epc_o,    32'h0);
        check("rst2_status", status_o, 32'h0);
        rd(5'd13, "rst2_cause", 32'h0);
        check("rst2_intp", {31'b0, int_pending}, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
